// File: rtl/axil_regfile_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_regfile_slave_if
// Brief    : AXI-Lite bundle between the EMIF-to-AXI-Lite bridge and the bank.
// Revision : 1.0
// ============================================================================
interface axil_regfile_slave_if;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;

    modport master (
        output s_axil_awvalid, s_axil_awaddr, s_axil_awprot,
        output s_axil_wvalid,  s_axil_wdata,  s_axil_wstrb,
        output s_axil_bready,
        output s_axil_arvalid, s_axil_araddr, s_axil_arprot,
        output s_axil_rready,
        input  s_axil_awready, s_axil_wready,
        input  s_axil_bvalid,  s_axil_bresp,
        input  s_axil_arready,
        input  s_axil_rvalid,  s_axil_rdata,  s_axil_rresp
    );

    modport slave (
        input  s_axil_awvalid, s_axil_awaddr, s_axil_awprot,
        input  s_axil_wvalid,  s_axil_wdata,  s_axil_wstrb,
        input  s_axil_bready,
        input  s_axil_arvalid, s_axil_araddr, s_axil_arprot,
        input  s_axil_rready,
        output s_axil_awready, s_axil_wready,
        output s_axil_bvalid,  s_axil_bresp,
        output s_axil_arready,
        output s_axil_rvalid,  s_axil_rdata,  s_axil_rresp
    );
endinterface
`default_nettype wire

// File: rtl/axil_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : axil_regfile_slave
// Brief    : AXI-Lite register bank (ID, CTRL, W1C STATUS, IRQ_MASK, scratch).
//            Define AXIL_REGFILE_RDCLR_EN to make STATUS reads clear-on-read.
// Revision : 1.0
// ============================================================================
module axil_regfile_slave #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'hE1F0_0001,
    parameter logic [31:0] CTRL_RST   = 32'h0000_0000
) (
    input  logic                 eclk,
    input  logic                 nrst,
    axil_regfile_slave_if.slave  s_axil,
    input  logic [31:0]          evt_in,
    output logic [31:0]          ctrl_out,
    output logic                 irq
);

    localparam int               IDX_W       = ADDR_WIDTH - 2;
    localparam int               NUM_SCR     = NUM_REGS - 4;
    localparam logic [31:0]      OOR_DATA    = 32'hDEAD_BEEF;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_MASK    = IDX_W'(3);

    typedef enum logic [2:0] {
        WR_IDLE = 3'd0,
        WR_AW   = 3'd1,
        WR_W    = 3'd2,
        WR_BOTH = 3'd3,
        WR_RESP = 3'd4
    } wr_state_t;

    wr_state_t        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       bresp_q;

    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    logic [31:0]      ctrl_q;
    logic [31:0]      status_q, status_d;
    logic [31:0]      mask_q;
    logic [31:0]      scratch_q [NUM_SCR];
    logic             irq_q;

    logic             aw_hs, w_hs, ar_hs;
    logic             wr_commit;
    logic             wr_idx_ok;
    logic [31:0]      wr_bmask;
    logic [31:0]      w1c_bits;
    logic [31:0]      rdclr_bits;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;
    logic [1:0]       rd_resp;
    logic             unused_ok;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    // Ready lines are pure decodes of the registered write state, so they
    // behave as registered outputs and drop the cycle after each handshake.
    assign s_axil.s_axil_awready = (wr_state_q == WR_IDLE) || (wr_state_q == WR_W);
    assign s_axil.s_axil_wready  = (wr_state_q == WR_IDLE) || (wr_state_q == WR_AW);
    assign s_axil.s_axil_bvalid  = (wr_state_q == WR_RESP);
    assign s_axil.s_axil_bresp   = bresp_q;
    assign s_axil.s_axil_arready = ~rvalid_q;
    assign s_axil.s_axil_rvalid  = rvalid_q;
    assign s_axil.s_axil_rdata   = rdata_q;
    assign s_axil.s_axil_rresp   = rresp_q;

    assign aw_hs     = s_axil.s_axil_awvalid & s_axil.s_axil_awready;
    assign w_hs      = s_axil.s_axil_wvalid  & s_axil.s_axil_wready;
    assign ar_hs     = s_axil.s_axil_arvalid & ~rvalid_q;
    assign wr_commit = (wr_state_q == WR_BOTH);
    assign wr_idx_ok = idx_ok(wr_idx_q);
    assign wr_bmask  = strb_mask(wstrb_q);
    assign rd_idx    = s_axil.s_axil_araddr[ADDR_WIDTH-1:2];

    assign unused_ok = ^{s_axil.s_axil_awprot, s_axil.s_axil_arprot,
                         s_axil.s_axil_awaddr, s_axil.s_axil_araddr};

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_BOTH;
                else if (aw_hs)    wr_state_d = WR_AW;
                else if (w_hs)     wr_state_d = WR_W;
            end
            WR_AW:   if (w_hs)  wr_state_d = WR_BOTH;
            WR_W:    if (aw_hs) wr_state_d = WR_BOTH;
            WR_BOTH: wr_state_d = WR_RESP;
            WR_RESP: if (s_axil.s_axil_bready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge eclk or negedge nrst) begin
        if (!nrst) begin
            wr_state_q <= WR_IDLE;
            wr_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) wr_idx_q <= s_axil.s_axil_awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= s_axil.s_axil_wdata;
                wstrb_q <= s_axil.s_axil_wstrb;
            end
            if (wr_commit) bresp_q <= wr_idx_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read mux works on pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        rd_data = OOR_DATA;
        rd_resp = RESP_SLVERR;
        if (idx_ok(rd_idx)) begin
            rd_resp = RESP_OKAY;
            rd_data = '0;
            if (rd_idx == IDX_ID)          rd_data = ID_VALUE;
            else if (rd_idx == IDX_CTRL)   rd_data = ctrl_q;
            else if (rd_idx == IDX_STATUS) rd_data = status_q;
            else if (rd_idx == IDX_MASK)   rd_data = mask_q;
            else begin
                for (int k = 0; k < NUM_SCR; k++) begin
                    if (rd_idx == IDX_W'(k + 4)) rd_data = scratch_q[k];
                end
            end
        end
    end

    always_ff @(posedge eclk or negedge nrst) begin
        if (!nrst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
        end else if (rvalid_q && s_axil.s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign w1c_bits = (wr_commit && wr_idx_q == IDX_STATUS) ? (wdata_q & wr_bmask) : '0;

`ifdef AXIL_REGFILE_RDCLR_EN
    assign rdclr_bits = (ar_hs && rd_idx == IDX_STATUS) ? status_q : '0;
`else
    assign rdclr_bits = '0;
`endif

    // OR-ing events after the clears lets a same-cycle event win.
    assign status_d = (status_q & ~(w1c_bits | rdclr_bits)) | evt_in;

    always_ff @(posedge eclk or negedge nrst) begin
        if (!nrst) begin
            ctrl_q   <= CTRL_RST;
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            for (int k = 0; k < NUM_SCR; k++) scratch_q[k] <= '0;
        end else begin
            status_q <= status_d;
            irq_q    <= |(status_q & mask_q);
            if (wr_commit && wr_idx_q == IDX_CTRL)
                ctrl_q <= merge(ctrl_q, wdata_q, wr_bmask);
            if (wr_commit && wr_idx_q == IDX_MASK)
                mask_q <= merge(mask_q, wdata_q, wr_bmask);
            for (int k = 0; k < NUM_SCR; k++) begin
                if (wr_commit && wr_idx_q == IDX_W'(k + 4))
                    scratch_q[k] <= merge(scratch_q[k], wdata_q, wr_bmask);
            end
        end
    end

    assign ctrl_out = ctrl_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_regfile_slave
// Brief    : Scoreboard bench for axil_regfile_slave with a register-map model.
// Revision : 1.0
// ============================================================================
module tb_axil_regfile_slave;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] ID_VALUE = 32'hE1F0_0001;
    localparam logic [31:0] CTRL_RST = 32'h0000_0000;
    localparam int          TO       = 64;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic        eclk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] evt_in;
    logic [31:0] ctrl_out;
    logic        irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_reg [NUM_REGS];
    logic [1:0]  q_b [$];
    rexp_t       q_r [$];

    axil_regfile_slave_if bus ();

    axil_regfile_slave #(
        .ADDR_WIDTH (16),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE),
        .CTRL_RST   (CTRL_RST)
    ) dut (
        .eclk     (eclk),
        .nrst     (nrst),
        .s_axil   (bus),
        .evt_in   (evt_in),
        .ctrl_out (ctrl_out),
        .irq      (irq)
    );

    always #5 eclk = ~eclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bm(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_REGS; k++) m_reg[k] = '0;
        m_reg[1] = CTRL_RST;
    endtask

    function automatic rexp_t model_read(input int idx);
        rexp_t e;
        if (idx >= NUM_REGS)  e = '{data: 32'hDEAD_BEEF, resp: 2'b10};
        else if (idx == 0)    e = '{data: ID_VALUE,      resp: 2'b00};
        else                  e = '{data: m_reg[idx],    resp: 2'b00};
        return e;
    endfunction

    function automatic logic model_irq();
        return |(m_reg[2] & m_reg[3]);
    endfunction

    // Random bits above the decoded range and in [1:0] must be ignored.
    function automatic logic [31:0] mk_addr(input int idx);
        logic [31:0] r;
        r = $urandom;
        return {r[31:16], 14'(idx), r[1:0]};
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0:       return bus.s_axil_awready;
            1:       return bus.s_axil_wready;
            2:       return bus.s_axil_bvalid;
            3:       return bus.s_axil_arready;
            4:       return bus.s_axil_rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input int w, input string name);
        int n;
        n = 0;
        @(negedge eclk);
        while (!sig(w)) begin
            n++;
            if (n > TO) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: still 0 after %0d cycles, required 1", name, TO);
                return;
            end
            @(negedge eclk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge eclk); #1; end
    endtask

    task automatic pulse_evt(input logic [31:0] v);
        evt_in   = v;
        m_reg[2] = m_reg[2] | v;
        @(posedge eclk); #1;
        evt_in   = '0;
    endtask

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                            input int skew, input int bdly);
        logic [31:0] a;
        a = mk_addr(idx);
        q_b.push_back((idx >= NUM_REGS) ? 2'b10 : 2'b00);
        if (idx < NUM_REGS && idx != 0) begin
            if (idx == 2) m_reg[2] = m_reg[2] & ~(d & bm(s));
            else          m_reg[idx] = (m_reg[idx] & ~bm(s)) | (d & bm(s));
        end
        fork
            begin : aw_p
                repeat ((skew > 0) ? skew : 0) begin @(posedge eclk); #1; end
                bus.s_axil_awaddr  = a;
                bus.s_axil_awvalid = 1'b1;
                wait_hi(0, "awready");
                @(posedge eclk); #1;
                bus.s_axil_awvalid = 1'b0;
            end
            begin : w_p
                repeat ((skew < 0) ? -skew : 0) begin @(posedge eclk); #1; end
                bus.s_axil_wdata  = d;
                bus.s_axil_wstrb  = s;
                bus.s_axil_wvalid = 1'b1;
                wait_hi(1, "wready");
                @(posedge eclk); #1;
                bus.s_axil_wvalid = 1'b0;
            end
            begin : b_p
                wait_hi(2, "bvalid");
                @(posedge eclk); #1;
                for (int i = 0; i < bdly; i++) begin
                    check("bvalid_hold", 32'(bus.s_axil_bvalid), 32'd1);
                    check("awready_blocked", 32'(bus.s_axil_awready), 32'd0);
                    @(posedge eclk); #1;
                end
                bus.s_axil_bready = 1'b1;
                @(posedge eclk); #1;
                bus.s_axil_bready = 1'b0;
            end
        join
    endtask

    task automatic do_read(input int idx, input int rdly);
        q_r.push_back(model_read(idx));
`ifdef AXIL_REGFILE_RDCLR_EN
        if (idx == 2) m_reg[2] = '0;
`endif
        bus.s_axil_araddr  = mk_addr(idx);
        bus.s_axil_arvalid = 1'b1;
        wait_hi(3, "arready");
        @(posedge eclk); #1;
        bus.s_axil_arvalid = 1'b0;
        wait_hi(4, "rvalid");
        @(posedge eclk); #1;
        for (int i = 0; i < rdly; i++) begin
            check("rvalid_hold", 32'(bus.s_axil_rvalid), 32'd1);
            check("arready_blocked", 32'(bus.s_axil_arready), 32'd0);
            @(posedge eclk); #1;
        end
        bus.s_axil_rready = 1'b1;
        @(posedge eclk); #1;
        bus.s_axil_rready = 1'b0;
    endtask

    // Monitor: pops the oldest expectation whenever a response handshake is seen.
    always @(negedge eclk) begin : mon
        rexp_t e;
        logic [1:0] eb;
        if (nrst) begin
            if (bus.s_axil_bvalid && bus.s_axil_bready) begin
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_unexpected: bresp %b seen, required no response", bus.s_axil_bresp);
                end else begin
                    eb = q_b.pop_front();
                    check("bresp", 32'(bus.s_axil_bresp), 32'(eb));
                end
            end
            if (bus.s_axil_rvalid && bus.s_axil_rready) begin
                if (q_r.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL r_unexpected: rdata %h seen, required no response", bus.s_axil_rdata);
                end else begin
                    e = q_r.pop_front();
                    check("rdata", bus.s_axil_rdata, e.data);
                    check("rresp", 32'(bus.s_axil_rresp), 32'(e.resp));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_awaddr  = '0;
        bus.s_axil_awprot  = '0;
        bus.s_axil_wvalid  = 1'b0;
        bus.s_axil_wdata   = '0;
        bus.s_axil_wstrb   = '0;
        bus.s_axil_bready  = 1'b0;
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_araddr  = '0;
        bus.s_axil_arprot  = '0;
        bus.s_axil_rready  = 1'b0;
        evt_in             = '0;
        model_reset();

        idle(3);
        check("rst_awready", 32'(bus.s_axil_awready), 32'd1);
        check("rst_wready",  32'(bus.s_axil_wready),  32'd1);
        check("rst_arready", 32'(bus.s_axil_arready), 32'd1);
        check("rst_bvalid",  32'(bus.s_axil_bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.s_axil_rvalid),  32'd0);
        check("rst_rdata",   bus.s_axil_rdata,        32'd0);
        check("rst_ctrl",    ctrl_out,                CTRL_RST);
        check("rst_irq",     32'(irq),                32'd0);
        nrst = 1'b1;
        idle(2);

        do_read(0, 0);
        do_read(1, 1);
        check("ctrl_after_rst", ctrl_out, CTRL_RST);

        do_write(1, 32'h1234_5678, 4'b0101, 0, 0);
        check("ctrl_strobed", ctrl_out, 32'h0034_0078);

        do_write(5, 32'hA5A5_0F0F, 4'hF, 3, 4);
        do_read(5, 0);
        do_write(6, 32'h0BAD_F00D, 4'hF, -2, 2);
        do_read(6, 2);

        do_write(3, 32'h0000_0020, 4'hF, 0, 0);
        pulse_evt(32'h0000_0020);
        check("irq_one_edge", 32'(irq), 32'd0);
        idle(1);
        check("irq_two_edges", 32'(irq), 32'd1);
        do_read(2, 0);
        do_write(2, 32'h0000_0020, 4'hF, 0, 0);
        idle(2);
        check("irq_after_w1c", 32'(irq), 32'(model_irq()));
        fork
            do_write(2, 32'h0000_0020, 4'hF, 0, 0);
            begin
                @(posedge eclk); #1;
                pulse_evt(32'h0000_0020);
            end
        join
        idle(2);
        check("irq_set_beats_clear", 32'(irq), 32'd1);
        do_read(2, 1);

        do_read(NUM_REGS, 0);
        do_write(NUM_REGS, 32'hFFFF_FFFF, 4'hF, 0, 1);
        for (int i = 0; i < NUM_REGS; i++) do_read(i, 0);

        do_write(2, 32'hFFFF_FFFF, 4'hF, 0, 0);
        pulse_evt(32'h0000_0003);
        do_read(2, 0);
        do_read(2, 0);

        bus.s_axil_awaddr  = mk_addr(1);
        bus.s_axil_awvalid = 1'b1;
        @(posedge eclk); #1;
        bus.s_axil_awvalid = 1'b0;
        check("aw_taken", 32'(bus.s_axil_awready), 32'd0);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_awready", 32'(bus.s_axil_awready), 32'd1);
        check("async_rst_ctrl",    ctrl_out,                CTRL_RST);
        check("async_rst_irq",     32'(irq),                32'd0);
        model_reset();
        @(posedge eclk); #1;
        nrst = 1'b1;
        idle(2);
        check("post_rst_wready", 32'(bus.s_axil_wready), 32'd1);
        do_read(1, 0);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 4))
                0, 1: do_write(int'($urandom_range(0, NUM_REGS + 1)), $urandom, 4'($urandom),
                               int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
                2, 3: do_read(int'($urandom_range(0, NUM_REGS + 1)), int'($urandom_range(0, 3)));
                default: pulse_evt($urandom & $urandom & $urandom);
            endcase
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        check("final_irq",  32'(irq), 32'(model_irq()));
        check("final_ctrl", ctrl_out, m_reg[1]);
        for (int i = 0; i < NUM_REGS; i++) do_read(i, 0);

        idle(5);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        check("r_queue_drained", 32'(q_r.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
AXI-Lite slave register bank that consumes the AXI-Lite master transactions produced by the EMIF-to-AXI-Lite bridge; it is the first endpoint behind that bridge.
- Provides an ID register, a control register, a sticky event/status register, an interrupt mask and a scratch array.
- Drives the control word, interrupt line and error responses back to the bridge.
- Single clock domain: eclk, which is the same clock the bridge exports as aclk.

Parameters:
ADDR_WIDTH, 16, number of low address bits decoded; higher awaddr/araddr bits are ignored.
NUM_REGS, 16, total 32-bit register slots; minimum 5, maximum 2^(ADDR_WIDTH-2).
ID_VALUE, 32'hE1F0_0001, constant returned by the ID register.
CTRL_RST, 32'h0000_0000, reset value of CTRL.

Ports:
eclk  in  1  clock
nrst  in  1  reset; asynchronous, active-low
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_awaddr  in  32  write byte address
s_axil_awprot  in  3  ignored
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte enables
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_bresp  out  2  00 OKAY, 10 SLVERR
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_araddr  in  32  read byte address
s_axil_arprot  in  3  ignored
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  00 OKAY, 10 SLVERR
evt_in  in  32  single-cycle event pulses, one per STATUS bit
ctrl_out  out  32  current CTRL value
irq  out  1  level interrupt, registered

Behaviour:
- Reset values: awready/wready/arready 1; bvalid/rvalid 0; bresp/rresp 00; rdata 0; CTRL=CTRL_RST; STATUS, IRQ_MASK and scratch 0; irq 0.
- Register index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
- Register map:
  - idx0 ID (RO; writes ignored, OKAY)
  - idx1 CTRL (RW)
  - idx2 STATUS (W1C)
  - idx3 IRQ_MASK (RW)
  - idx4..NUM_REGS-1 scratch (RW)
- Out-of-range index (>= NUM_REGS): read returns 32'hDEAD_BEEF with SLVERR; write has no effect and returns SLVERR.
- Write channel:
  - AW and W are accepted independently.
  - awready drops the cycle after the AW handshake; wready drops the cycle after the W handshake.
  - Once both are held, the register update occurs on the next edge and bvalid asserts on that same edge.
  - bvalid holds until bready. awready and wready both re-assert on the edge where the B handshake completes. No second write is accepted while a write is pending or bvalid=1.
- wstrb: only enabled bytes update RW and scratch registers. For STATUS, a 1 in an enabled byte clears that bit.
- Read channel:
  - AR handshake -> rvalid=1 on the next edge, with rdata sampled from the register state before that edge.
  - arready=0 while rvalid=1. rvalid, rdata and rresp are held until rready. arready returns to 1 on the edge where the R handshake completes.
- STATUS: each evt_in bit sets its bit every cycle it is 1. Set beats clear when both hit the same bit in the same cycle.
- irq <= |(STATUS & IRQ_MASK), registered, so irq rises 2 edges after the evt_in pulse edge.
- Simultaneous read and write: the channels are independent. A read of a register written in the same cycle returns the pre-write value.
- Reset mid-transaction: all pending handshakes are abandoned and all outputs return to reset values immediately.

Optional Feature:
Macro: AXIL_REGFILE_RDCLR_EN.
- Defined: a completed AR to STATUS also clears, on the AR handshake edge, exactly the bits captured into rdata. Bits set by evt_in on that same edge survive. W1C still works.
- Undefined: STATUS reads have no side effect; clearing is by W1C only.

Test Plan:
- Reset: after nrst release, read idx0 -> rdata 32'hE1F0_0001, OKAY; read idx1 -> CTRL_RST; ctrl_out = CTRL_RST.
- Write idx1 with wdata 32'h1234_5678 and wstrb 4'b0101, starting from 0 -> ctrl_out 32'h0034_0078; bresp OKAY.
- Skewed channels: W presented 3 cycles before AW, with bready low for 4 cycles -> exactly one write; bvalid held; no second AW accepted until the B handshake.
- evt_in bit 5 pulsed with IRQ_MASK=32'h20 -> STATUS=32'h20; irq high 2 edges later. Write 32'h20 to STATUS -> irq low; repeat the write in the same cycle as a new evt_in[5] pulse -> bit stays set.
- Read index NUM_REGS (addr 0x40 at default) -> rdata 32'hDEAD_BEEF, rresp 10; write to the same address -> bresp 10 and no register changes.
- With AXIL_REGFILE_RDCLR_EN, STATUS=32'h3 -> read returns 32'h3, then a second read returns 32'h0; without the macro, the second read returns 32'h3.
